vram_write_port: RTL and testbench
==================================

// Module: vram_write_port
// PURPOSE
//  Owns the 6912-byte screen RAM (6144 B pixels, 768 B attributes at 6144). Serves the video
//  datapath's read requests with absolute priority, 1-cycle latency. Buffers CPU writes in a small
//  FIFO drained on cycles the video side is idle. Serves coherent CPU reads via a req/ack handshake.
//  Sits between the Z80 bus decoder and the pixel/attribute fetch pipeline.
// PARAMETERS
//  ADDR_W      13    address width, both ports
//  DEPTH       6912  bytes of RAM; addresses >= DEPTH are out of range
//  FIFO_DEPTH  4     CPU write-buffer entries (power of two)
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       reset, asynchronous, active-low
//  video_rd     in   1       video read strobe (display-enable window)
//  video_addr   in   ADDR_W  video read address
//  video_dout   out  8       video read data
//  cpu_req      in   1       CPU request, level, held until cpu_ack
//  cpu_we       in   1       1 = write, 0 = read; stable while cpu_req=1
//  cpu_addr     in   ADDR_W  CPU address; stable while cpu_req=1
//  cpu_wdata    in   8       CPU write data
//  cpu_ack      out  1       one-cycle completion pulse
//  cpu_rdata    out  8       CPU read data, valid with cpu_ack, held after
//  wr_pending   out  1       1 while the write FIFO is non-empty
// BEHAVIOUR
//  - Reset (async, reset_n=0): FIFO pointers/count=0, FSM=IDLE, video_dout=0, cpu_ack=0,
//    cpu_rdata=0, wr_pending=0. RAM contents are not cleared. Requests in flight are discarded.
//  - RAM: single-port, one access per cycle. Priority: video > FIFO drain > CPU read.
//  - Video: every edge with video_rd=1 reads video_addr. video_dout is updated at the next edge
//    (1-cycle latency). With video_rd=0, video_dout holds. There is no forwarding from the FIFO;
//    video sees old data until the entry drains. Out-of-range video addr returns 8'h00.
//  - FIFO drain: on an edge with video_rd=0 and count>0, the head entry is written to RAM and
//    popped. The drain is dropped silently if its address >= DEPTH.
//  - CPU FSM states IDLE, RD_WAIT, RD_DATA:
//    IDLE, cpu_req=1, cpu_ack=0, cpu_we=1: if count<FIFO_DEPTH (registered count) push
//      {addr,data} and pulse cpu_ack next cycle. If full, wait in IDLE.
//    IDLE, cpu_req=1, cpu_ack=0, cpu_we=0: go to RD_WAIT.
//    RD_WAIT: when video_rd=0 and count=0, issue the RAM read and go to RD_DATA.
//    RD_DATA: latch cpu_rdata (8'hFF if addr>=DEPTH), pulse cpu_ack, return to IDLE.
//  - cpu_req is ignored while cpu_ack=1. The master drops req in the ack cycle. At most one
//    transaction is outstanding.
//  - Push and pop in the same edge: count unchanged. Push is gated on the pre-edge count, so a
//    full FIFO with a simultaneous pop does not accept that cycle.
//  - Pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits wide.
//  - Writes drain in issue order. A CPU read always observes every previously acked write.
//  - Continuous video_rd=1 starves the CPU indefinitely. This is by design; blanking
//    guarantees drain time.
// TESTING
//  1. video_rd=0: write 8'hA5 to 6144 -> cpu_ack 1 cycle later. Next cycle: video_rd=1,
//     addr=6144 -> video_dout=8'hA5 one edge later.
//  2. video_rd=1 held, 5 writes to 0..4 -> 4 acked, wr_pending=1, 5th unacked. video_rd=0 ->
//     5th acks after the first pop. RAM[0..4] correct after 5 drain cycles.
//  3. video_rd=1: write 8'h3C to 0x0100, then read 0x0100 -> no ack while video_rd=1. After
//     video_rd=0: ack with cpu_rdata=8'h3C only after wr_pending=0.
//  4. Write 8'h55 to 7000 -> acked, RAM unchanged. Read 7000 -> cpu_ack with cpu_rdata=8'hFF.
//  5. FIFO holds 3 entries, read in RD_WAIT, reset_n pulsed low off-edge -> outputs 0
//     immediately, wr_pending=0, no ack after release. Prior RAM contents intact.
//  6. Full FIFO, video_rd=0, new write held -> pop and push on separate edges, count never
//     exceeds 4, data order preserved.

Source files
------------

// File: rtl/vram_write_port_if.sv
// rtl/vram_write_port_if.sv - video read, CPU request and write-buffer status signals of the screen RAM port
interface vram_write_port_if #(
    parameter int ADDR_W = 13
);
    logic              video_rd;
    logic [ADDR_W-1:0] video_addr;
    logic [7:0]        video_dout;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              wr_pending;

    modport master (
        output video_rd, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  video_dout, cpu_ack, cpu_rdata, wr_pending
    );

    modport slave (
        input  video_rd, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output video_dout, cpu_ack, cpu_rdata, wr_pending
    );
endinterface

// File: rtl/vram_write_port.sv
// rtl/vram_write_port.sv - screen RAM with video-priority reads, buffered CPU writes and coherent CPU reads
module vram_write_port #(
    parameter int ADDR_W     = 13,
    parameter int DEPTH      = 6912,
    parameter int FIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                reset_n,
    vram_write_port_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA} state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [7:0]        rd_buf;
    logic [7:0]        vdout_q, rdata_q;
    logic              ack_q, ack_d;
    logic              push, pop, rd_issue;
    logic              video_in_range, cpu_in_range, head_in_range;

    assign video_in_range = bus.video_addr < DEPTH_A;
    assign cpu_in_range   = bus.cpu_addr < DEPTH_A;
    assign head_in_range  = fifo_addr[rd_ptr] < DEPTH_A;

    // Video owns the RAM whenever it asks; drains and CPU reads only get idle cycles.
    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        rd_issue = 1'b0;
        ack_d    = 1'b0;
        pop      = !bus.video_rd && (count != '0);
        case (state_q)
            IDLE: begin
                if (bus.cpu_req && !ack_q) begin
                    if (bus.cpu_we) begin
                        if (count < FULL_CNT) begin
                            push  = 1'b1;
                            ack_d = 1'b1;
                        end
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            // Waiting for an empty FIFO makes the read see every acked write.
            RD_WAIT: begin
                if (!bus.video_rd && (count == '0)) begin
                    rd_issue = 1'b1;
                    state_d  = RD_DATA;
                end
            end
            RD_DATA: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ack_q   <= 1'b0;
            vdout_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (bus.video_rd)
                vdout_q <= video_in_range ? mem[bus.video_addr] : 8'h00;
            if (state_q == RD_DATA)
                rdata_q <= cpu_in_range ? rd_buf : 8'hFF;
        end
    end

    // Storage without reset: RAM contents survive reset by design.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.cpu_addr;
            fifo_data[wr_ptr] <= bus.cpu_wdata;
        end
        if (pop && head_in_range)
            mem[fifo_addr[rd_ptr]] <= fifo_data[rd_ptr];
        if (rd_issue)
            rd_buf <= mem[bus.cpu_addr];
    end

    assign bus.video_dout = vdout_q;
    assign bus.cpu_ack    = ack_q;
    assign bus.cpu_rdata  = rdata_q;
    assign bus.wr_pending = (count != '0);
endmodule

// File: tb/tb_vram_write_port.sv
// tb/tb_vram_write_port.sv - directed bench with a transaction-level model of the screen RAM port
module tb_vram_write_port;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 6912;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    vram_write_port_if #(.ADDR_W(ADDR_W)) bus();

    vram_write_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    logic [7:0] m_ram [DEPTH];
    bit         m_known [DEPTH];
    wr_t        m_q [$];
    wr_t        m_h;
    logic [7:0] e_vdout = 8'h00;
    logic [7:0] e_rdata = 8'h00;
    logic [7:0] rd_snap = 8'h00;
    bit         e_vknown = 1'b1;
    bit         e_rknown = 1'b1;
    bit         rd_snap_known = 1'b1;
    bit         e_ack = 1'b0;
    bit         m_nack, m_push;
    int         m_n;
    int         rd_phase = 0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending writes, a byte array for RAM, and a read that completes one
    // edge after the RAM becomes free with nothing queued.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_q.delete();
            rd_phase = 0;
            e_ack    = 1'b0;
            e_vdout  = 8'h00;
            e_vknown = 1'b1;
            e_rdata  = 8'h00;
            e_rknown = 1'b1;
        end else begin
            m_n    = m_q.size();
            m_nack = 1'b0;
            m_push = 1'b0;
            if (bus.video_rd) begin
                if (bus.video_addr >= ADDR_W'(DEPTH)) begin
                    e_vdout  = 8'h00;
                    e_vknown = 1'b1;
                end else begin
                    e_vdout  = m_ram[bus.video_addr];
                    e_vknown = m_known[bus.video_addr];
                end
            end
            if (rd_phase == 2) begin
                e_rdata  = rd_snap;
                e_rknown = rd_snap_known;
                m_nack   = 1'b1;
                rd_phase = 0;
            end else if (rd_phase == 1) begin
                if (!bus.video_rd && m_n == 0) begin
                    if (bus.cpu_addr >= ADDR_W'(DEPTH)) begin
                        rd_snap       = 8'hFF;
                        rd_snap_known = 1'b1;
                    end else begin
                        rd_snap       = m_ram[bus.cpu_addr];
                        rd_snap_known = m_known[bus.cpu_addr];
                    end
                    rd_phase = 2;
                end
            end else if (bus.cpu_req && !e_ack) begin
                if (bus.cpu_we) begin
                    if (m_n < 4) begin
                        m_push = 1'b1;
                        m_nack = 1'b1;
                    end
                end else begin
                    rd_phase = 1;
                end
            end
            if (!bus.video_rd && m_n > 0) begin
                m_h = m_q.pop_front();
                if (m_h.a < ADDR_W'(DEPTH)) begin
                    m_ram[m_h.a]   = m_h.d;
                    m_known[m_h.a] = 1'b1;
                end
            end
            if (m_push) m_q.push_back({bus.cpu_addr, bus.cpu_wdata});
            e_ack = m_nack;
        end
    end

    initial forever begin
        @(negedge clk);
        if (e_vknown) check("video_dout", bus.video_dout, e_vdout);
        check("cpu_ack", {7'b0, bus.cpu_ack}, {7'b0, e_ack});
        if (e_rknown) check("cpu_rdata", bus.cpu_rdata, e_rdata);
        check("wr_pending", {7'b0, bus.wr_pending}, {7'b0, (m_q.size() != 0)});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic cpu_start(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic cpu_wait(input int budget, output bit acked);
        acked = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (bus.cpu_ack) begin
                acked = 1'b1;
                break;
            end
        end
        if (acked) bus.cpu_req = 1'b0;
    endtask

    task automatic cpu_xfer(input string name, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [7:0] d);
        bit ok;
        cpu_start(we, a, d);
        cpu_wait(20, ok);
        check(name, {7'b0, ok}, 8'h01);
    endtask

    task automatic vread(input string name, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        bus.video_rd   = 1'b1;
        bus.video_addr = a;
        tick(1);
        check(name, bus.video_dout, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.video_rd   = 1'b0;
        bus.video_addr = '0;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = 8'h00;
        tick(2);
        check("rst_video_dout", bus.video_dout, 8'h00);
        check("rst_cpu_ack", {7'b0, bus.cpu_ack}, 8'h00);
        check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        check("rst_wr_pending", {7'b0, bus.wr_pending}, 8'h00);
        reset_n = 1'b1;
        tick(2);

        // 1: write then video read-back
        cpu_start(1'b1, 13'd6144, 8'hA5);
        tick(1);
        check("t1_ack_latency", {7'b0, bus.cpu_ack}, 8'h01);
        bus.cpu_req = 1'b0;
        tick(1);
        vread("t1_video_a5", 13'd6144, 8'hA5);

        // 2: FIFO fills under continuous video reads
        for (int i = 0; i < 4; i++)
            cpu_xfer("t2_ack", 1'b1, ADDR_W'(i), 8'(8'h10 + i));
        check("t2_wr_pending", {7'b0, bus.wr_pending}, 8'h01);
        cpu_start(1'b1, 13'd4, 8'h14);
        cpu_wait(8, ok);
        check("t2_fifth_blocked", {7'b0, ok}, 8'h00);
        bus.video_rd = 1'b0;
        cpu_wait(10, ok);
        check("t2_fifth_acked", {7'b0, ok}, 8'h01);
        tick(6);
        check("t2_drained", {7'b0, bus.wr_pending}, 8'h00);
        for (int i = 0; i < 5; i++)
            vread("t2_ram", ADDR_W'(i), 8'(8'h10 + i));

        // 3: read waits for blanking and for the FIFO to drain
        bus.video_addr = 13'd6144;
        cpu_xfer("t3_wr_ack", 1'b1, 13'h100, 8'h3C);
        cpu_start(1'b0, 13'h100, 8'h00);
        cpu_wait(6, ok);
        check("t3_rd_blocked", {7'b0, ok}, 8'h00);
        bus.video_rd = 1'b0;
        cpu_wait(10, ok);
        check("t3_rd_acked", {7'b0, ok}, 8'h01);
        check("t3_rdata", bus.cpu_rdata, 8'h3C);
        check("t3_pending_clear", {7'b0, bus.wr_pending}, 8'h00);

        // 4: out-of-range addresses
        cpu_xfer("t4_wr_ack", 1'b1, 13'd7000, 8'h55);
        tick(3);
        cpu_xfer("t4_rd_ack", 1'b0, 13'd7000, 8'h00);
        check("t4_rdata_ff", bus.cpu_rdata, 8'hFF);
        vread("t4_video_oob", 13'd7000, 8'h00);

        // 5: asynchronous reset with queued writes and a waiting read
        vread("t5_video_pre", 13'd6144, 8'hA5);
        cpu_xfer("t5_wr0", 1'b1, 13'd6144, 8'h77);
        cpu_xfer("t5_wr1", 1'b1, 13'h100, 8'h88);
        cpu_xfer("t5_wr2", 1'b1, 13'h101, 8'h99);
        cpu_start(1'b0, 13'h100, 8'h00);
        tick(2);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_rst_video_dout", bus.video_dout, 8'h00);
        check("t5_rst_cpu_ack", {7'b0, bus.cpu_ack}, 8'h00);
        check("t5_rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        check("t5_rst_wr_pending", {7'b0, bus.wr_pending}, 8'h00);
        bus.cpu_req  = 1'b0;
        bus.video_rd = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(4);
        check("t5_no_ack", {7'b0, bus.cpu_ack}, 8'h00);
        vread("t5_ram_kept_a5", 13'd6144, 8'hA5);
        vread("t5_ram_kept_3c", 13'h100, 8'h3C);

        // 6: full FIFO, pop and push on separate edges, order preserved
        bus.video_addr = 13'd6144;
        cpu_xfer("t6_wr0", 1'b1, 13'h200, 8'h01);
        cpu_xfer("t6_wr1", 1'b1, 13'h201, 8'h02);
        cpu_xfer("t6_wr2", 1'b1, 13'h200, 8'h03);
        cpu_xfer("t6_wr3", 1'b1, 13'h202, 8'h04);
        cpu_start(1'b1, 13'h201, 8'h05);
        cpu_wait(4, ok);
        check("t6_full_blocked", {7'b0, ok}, 8'h00);
        bus.video_rd = 1'b0;
        cpu_wait(1, ok);
        check("t6_pop_only_edge", {7'b0, ok}, 8'h00);
        cpu_wait(1, ok);
        check("t6_push_pop_edge", {7'b0, ok}, 8'h01);
        tick(6);
        vread("t6_ram_200", 13'h200, 8'h03);
        vread("t6_ram_201", 13'h201, 8'h05);
        vread("t6_ram_202", 13'h202, 8'h04);
        bus.video_rd = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
